// File: rtl/i2s_tx_v_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_v_if
// Brief    : Sample-pair handshake bundle between the synthesis engine and
//            the I2S transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_tx_v_if #(
    parameter int DATA_W = 24
) ();
    logic              sample_valid_i;
    logic              sample_ready_o;
    logic [DATA_W-1:0] sample_l_i;
    logic [DATA_W-1:0] sample_r_i;

    modport master (
        output sample_valid_i,
        output sample_l_i,
        output sample_r_i,
        input  sample_ready_o
    );

    modport slave (
        input  sample_valid_i,
        input  sample_l_i,
        input  sample_r_i,
        output sample_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/i2s_tx_v.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_v
// Brief    : Stereo I2S serial-data transmitter. Buffers sample pairs in a
//            small FIFO and shifts one 64-bit frame out per LRCLK period.
//            Optional build macro I2S_TX_HOLD_LAST_EN repeats the last pair
//            on underrun instead of sending silence.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx_v #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                        clk_i,
    input  wire logic                        rst_n_i,
    input  wire logic                        bclk_i,
    input  wire logic                        lrclk_i,
    input  wire logic                        sampstart_i,
    i2s_tx_v_if.slave                        smp,
    output logic                             sdata_o,
    output logic                             underrun_o,
    output logic [$clog2(FIFO_DEPTH):0]      level_o
);

    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_LW     = c_AW + 1;
    localparam int c_PAIR_W = 2 * DATA_W;

    if (DATA_W < 16 || DATA_W > 32) begin : g_bad_data_w
        $error("i2s_tx_v: DATA_W must be within 16..32");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("i2s_tx_v: FIFO_DEPTH must be a power of 2, at least 2");
    end

    // Each channel sits left-justified in its own 32-bit slot, left first.
    function automatic logic [63:0] frame_of(input logic [c_PAIR_W-1:0] pair);
        logic [63:0] f;
        f = '0;
        f[63 -: DATA_W] = pair[c_PAIR_W-1 -: DATA_W];
        f[31 -: DATA_W] = pair[DATA_W-1:0];
        return f;
    endfunction

    logic [c_PAIR_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]     r_wptr;
    logic [c_AW-1:0]     r_rptr;
    logic [c_LW-1:0]     r_level;
    logic                r_bclk_q;
    logic                r_sdata;
    logic                r_underrun;
    logic [63:0]         r_shreg;

    logic                w_bfall;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_under;
    logic [c_PAIR_W-1:0] w_head;
    logic [63:0]         w_fill;
    logic [63:0]         w_load;
    logic                w_unused_lrclk;

    // LRCLK framing is carried entirely by the sample-start strobe.
    assign w_unused_lrclk = lrclk_i;

    assign w_bfall = ~bclk_i & r_bclk_q;
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_LW'(FIFO_DEPTH));
    // Fullness is judged before any same-cycle pop, so a full FIFO refuses.
    assign w_push  = smp.sample_valid_i & ~w_full;
    assign w_pop   = sampstart_i & ~w_empty;
    assign w_under = sampstart_i & w_empty;
    assign w_head  = r_mem[r_rptr];

`ifdef I2S_TX_HOLD_LAST_EN
    logic [c_PAIR_W-1:0] r_last;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last <= '0;
        end else if (w_pop) begin
            r_last <= w_head;
        end
    end

    assign w_fill = frame_of(r_last);
`else
    assign w_fill = '0;
`endif

    assign w_load = w_empty ? w_fill : frame_of(w_head);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {smp.sample_l_i, smp.sample_r_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_bclk_q   <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
            r_shreg    <= '0;
        end else begin
            r_bclk_q   <= bclk_i;
            r_underrun <= w_under;

            // The strobe coincides with a BCLK fall; it emits the old bit 0,
            // which is what delays the new MSB by one BCLK.
            if (sampstart_i || w_bfall) begin
                r_sdata <= r_shreg[63];
            end
            if (sampstart_i) begin
                r_shreg <= w_load;
            end else if (w_bfall) begin
                r_shreg <= {r_shreg[62:0], 1'b0};
            end

            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign sdata_o            = r_sdata;
    assign underrun_o         = r_underrun;
    assign level_o            = r_level;
    assign smp.sample_ready_o = ~w_full;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_v.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx_v
// Brief    : Self-checking bench for i2s_tx_v: directed frame vectors plus
//            randomized traffic against a queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_v;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 4;

    typedef logic [2*DATA_W-1:0] pair_t;
    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
        logic [63:0]       frame;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bclk_i;
    logic       lrclk_i;
    logic       sampstart_i;
    logic       sdata_o;
    logic       underrun_o;
    logic [2:0] level_o;
    logic       gen_en;
    int         cnt;

    int checks = 0;
    int errors = 0;
    int n_under = 0;

    always #5 clk = ~clk;

    i2s_tx_v_if #(.DATA_W(DATA_W)) sif ();

    i2s_tx_v #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bclk_i      (bclk_i),
        .lrclk_i     (lrclk_i),
        .sampstart_i (sampstart_i),
        .smp         (sif.slave),
        .sdata_o     (sdata_o),
        .underrun_o  (underrun_o),
        .level_o     (level_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Clock generator stand-in: BCLK = clk/4, 64 BCLK per frame; the strobe
    // lands on the BCLK falling edge that opens the left slot.
    initial begin
        cnt = 0; bclk_i = 1'b1; lrclk_i = 1'b1; sampstart_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!gen_en) begin
                cnt = 0; bclk_i = 1'b1; lrclk_i = 1'b1; sampstart_i = 1'b0;
            end else begin
                cnt         = (cnt + 1) % 256;
                bclk_i      = (cnt % 4) < 2;
                sampstart_i = (cnt == 2);
                lrclk_i     = ((cnt + 254) % 256) >= 128;
            end
        end
    end

    // Reference model: a queue of pairs, the frame being sent, and how many
    // of its bits have gone out.
    pair_t       mq[$];
    pair_t       m_last  = '0;
    logic [63:0] m_cur   = '0;
    int          m_sent  = 0;
    logic        m_sdata = 1'b0;
    logic        m_under = 1'b0;
    logic        m_bprev = 1'b0;
    logic        m_bfall;
    logic        m_push;

    function automatic logic [63:0] frame_of(input pair_t p);
        logic [31:0] hi, lo;
        hi = 32'(p[2*DATA_W-1:DATA_W]) << (32 - DATA_W);
        lo = 32'(p[DATA_W-1:0]) << (32 - DATA_W);
        return {hi, lo};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_last = '0; m_cur = '0; m_sent = 0;
            m_sdata = 1'b0; m_under = 1'b0; m_bprev = 1'b0;
        end else begin
            m_bfall = !bclk_i && m_bprev;
            m_bprev = bclk_i;
            m_push  = sif.sample_valid_i && (mq.size() < DEPTH);
            m_under = 1'b0;
            if (sampstart_i || m_bfall) begin
                m_sdata = (m_sent < 64) ? m_cur[63 - m_sent] : 1'b0;
                if (m_sent < 64) m_sent++;
            end
            if (sampstart_i) begin
                if (mq.size() == 0) begin
                    m_under = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                    m_cur = frame_of(m_last);
`else
                    m_cur = '0;
`endif
                end else begin
                    m_last = mq.pop_front();
                    m_cur  = frame_of(m_last);
                end
                m_sent = 0;
            end
            if (m_push) mq.push_back({sif.sample_l_i, sif.sample_r_i});
        end
    end

    always @(negedge clk) begin
        chk("sdata",    64'(sdata_o),            64'(m_sdata));
        chk("underrun", 64'(underrun_o),         64'(m_under));
        chk("level",    64'(level_o),            64'(mq.size()));
        chk("ready",    64'(sif.sample_ready_o), 64'(mq.size() != DEPTH));
        if (underrun_o) n_under++;
    end

    task automatic wait_ss(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (sampstart_i) begin ok = 1'b1; return; end
        end
        chk("sampstart_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rise(output bit ok);
        logic p;
        ok = 1'b0;
        p  = bclk_i;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (bclk_i && !p) begin ok = 1'b1; return; end
            p = bclk_i;
        end
        chk("bclk_timeout", 64'd0, 64'd1);
    endtask

    logic [63:0] cap [4];

    // Captures n frames on BCLK rises, skipping the rise that still carries
    // the previous frame's last bit.
    task automatic capture_frames(input int n, input bit already);
        bit ok;
        for (int i = 0; i < 4; i++) cap[i] = 'x;
        if (!already) begin
            wait_ss(ok);
            if (!ok) return;
        end
        wait_rise(ok);
        if (!ok) return;
        for (int i = 0; i < n * 64; i++) begin
            wait_rise(ok);
            if (!ok) return;
            cap[i / 64][63 - (i % 64)] = sdata_o;
        end
    endtask

    task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        @(negedge clk);
        sif.sample_valid_i = 1'b1;
        sif.sample_l_i     = l;
        sif.sample_r_i     = r;
        @(posedge clk);
        #2;
        sif.sample_valid_i = 1'b0;
    endtask

    vec_t tbl [4];

    initial begin
        bit ok;
        int nu0;
        tbl[0] = '{24'hA5A5A5, 24'h5A5A5A, 64'hA5A5A500_5A5A5A00};
        tbl[1] = '{24'h123456, 24'h654321, 64'h12345600_65432100};
        tbl[2] = '{24'hFFFFFF, 24'h000001, 64'hFFFFFF00_00000100};
        tbl[3] = '{24'h800000, 24'h7FFFFF, 64'h80000000_7FFFFF00};

        rst_n = 1'b0; gen_en = 1'b0;
        sif.sample_valid_i = 1'b0; sif.sample_l_i = '0; sif.sample_r_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_sdata",    64'(sdata_o),            64'd0);
        chk("rst_ready",    64'(sif.sample_ready_o), 64'd1);
        chk("rst_level",    64'(level_o),            64'd0);
        chk("rst_underrun", 64'(underrun_o),         64'd0);
        @(posedge clk); #3; rst_n = 1'b1;

        // Free run with an empty FIFO: one underrun per frame, silence.
        nu0 = n_under;
        gen_en = 1'b1;
        repeat (3) wait_ss(ok);
        repeat (2) @(negedge clk);
        chk("freerun_underruns", 64'(n_under - nu0), 64'd3);

        for (int i = 0; i < 4; i++) begin
            wait_ss(ok);
            push_pair(tbl[i].l, tbl[i].r);
            capture_frames(1, 1'b0);
            chk($sformatf("frame%0d", i), cap[0], tbl[i].frame);
        end

        // Underrun after a single pair.
        wait_ss(ok);
        push_pair(tbl[1].l, tbl[1].r);
        nu0 = n_under;
        capture_frames(2, 1'b0);
        chk("underrun_first", cap[0], tbl[1].frame);
`ifdef I2S_TX_HOLD_LAST_EN
        chk("underrun_repeat", cap[1], tbl[1].frame);
`else
        chk("underrun_silence", cap[1], 64'd0);
`endif
        chk("underrun_pulses", 64'(n_under - nu0), 64'd2);

        // Fill with the generator stopped, then a push racing the pop.
        gen_en = 1'b0;
        for (int i = 0; i < 4; i++) push_pair(tbl[i].l, tbl[i].r);
        @(negedge clk);
        chk("full_level", 64'(level_o),            64'd4);
        chk("full_ready", 64'(sif.sample_ready_o), 64'd0);
        push_pair(24'h0F0F0F, 24'hF0F0F0);
        @(negedge clk);
        chk("fifth_refused", 64'(level_o), 64'd4);
        @(negedge clk);
        sif.sample_valid_i = 1'b1;
        sif.sample_l_i = 24'h0F0F0F; sif.sample_r_i = 24'hF0F0F0;
        gen_en = 1'b1;
        wait_ss(ok);
        @(posedge clk); #2;
        sif.sample_valid_i = 1'b0;
        @(negedge clk);
        chk("full_pop_level", 64'(level_o),            64'd3);
        chk("full_pop_ready", 64'(sif.sample_ready_o), 64'd1);
        capture_frames(4, 1'b1);
        for (int i = 0; i < 4; i++) chk($sformatf("fifo_order%0d", i), cap[i], tbl[i].frame);

        // Asynchronous reset in the middle of a frame.
        push_pair(24'hFFFFFF, 24'hFFFFFF);
        push_pair(24'hFFFFFF, 24'hFFFFFF);
        wait_ss(ok);
        repeat (20) @(negedge clk);
        chk("pre_reset_sdata", 64'(sdata_o), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_sdata", 64'(sdata_o),            64'd0);
        chk("async_level", 64'(level_o),            64'd0);
        chk("async_ready", 64'(sif.sample_ready_o), 64'd1);
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1;
        push_pair(tbl[3].l, tbl[3].r);
        capture_frames(1, 1'b0);
        chk("post_reset_frame", cap[0], tbl[3].frame);

        // Random traffic: sparse pushes (underruns), then dense (full FIFO).
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            sif.sample_valid_i = (c < 1500) ? ($urandom_range(0, 63) == 0)
                                            : ($urandom_range(0, 1) == 0);
            sif.sample_l_i = DATA_W'($urandom);
            sif.sample_r_i = DATA_W'($urandom);
        end
        @(posedge clk); #2;
        sif.sample_valid_i = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/i2s_tx_v.md
# i2s_tx_v

Stereo I2S serial-data transmitter, the stage directly downstream of the audio clock generator. It buffers stereo sample pairs from the synthesis engine in a small FIFO. At each sample start, it loads one pair into a 64-bit frame shift register. It drives the codec's serial data line in standard I2S format, using the generator's BCLK, LRCLK and sample-start strobe, all of which are synchronous to clk_i.

## Interface
- DATA_W, 24, sample width per channel in bits; legal range 16..32.
- FIFO_DEPTH, 4, sample-pair FIFO depth; must be a power of 2, at least 2.
- clk_i  in  1  system clock; the same clock that drives the audio clock generator.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- bclk_i  in  1  bit clock from the generator (64x Fs).
- lrclk_i  in  1  L/R clock from the generator; low = left slot.
- sampstart_i  in  1  one-cycle sample-start strobe from the generator (LRCLK falling edge).
- sample_valid_i  in  1  a sample pair is offered.
- sample_ready_o  out  1  FIFO can accept a pair.
- sample_l_i  in  DATA_W  left sample, two's complement.
- sample_r_i  in  DATA_W  right sample, two's complement.
- sdata_o  out  1  I2S serial data to the codec.
- underrun_o  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values:
  - sdata_o=0, sample_ready_o=1, underrun_o=0, level_o=0.
  - Shift register, last-pair register and bclk history register are all 0.
  - FIFO pointers are 0.
- Push:
  - A push occurs when sample_valid_i and sample_ready_o are both high on a clk_i edge.
  - {sample_l_i, sample_r_i} is written and level increments.
  - sample_ready_o = (level_o != FIFO_DEPTH), decoded from registered level.
  - A push offered while full is not accepted, even if a pop happens in the same cycle.
- Bit strobe: bfall = !bclk_i & bclk_q, where bclk_q is bclk_i delayed by one clk_i.
- Frame word: {L, (32-DATA_W) zeros, R, (32-DATA_W) zeros}, 64 bits, MSB first. Each channel is left-justified in a 32-bit slot.
- On bfall without sampstart_i:
  - sdata_o <= shreg[63].
  - shreg <= {shreg[62:0], 1'b0}.
- On sampstart_i (with or without bfall):
  - sdata_o <= shreg[63]. This outputs the previous frame's final bit, which gives the I2S one-BCLK MSB delay.
  - shreg <= frame word of the FIFO head, and the head is popped (level decrements).
  - If the FIFO is empty, the underrun source is loaded instead (see Configuration) and underrun_o pulses for 1 cycle.
- Push and pop in the same cycle:
  - Non-empty FIFO: level is unchanged.
  - Empty FIFO: the pop underruns, the push is stored, and level becomes 1.
- Pointers wrap modulo FIFO_DEPTH.
- Level arithmetic is width $clog2(FIFO_DEPTH)+1 and never exceeds FIFO_DEPTH.
- Asynchronous reset mid-frame returns all state to reset values immediately. Output resumes with a fresh frame at the first sampstart_i after release.

## Timing
- sdata_o changes only in the clk_i cycle after a BCLK falling edge, i.e. one clk_i after bfall or sampstart_i is seen. It is therefore stable across the BCLK rising edge.
- There are 64 bfall per LRCLK period: 1 coincident with sampstart_i plus 63 others.
- After the load at sampstart N, sdata_o carries the left MSB at the next bfall.
  - Bits 63..1 go out over the next 63 bfall.
  - Bit 0 goes out at sampstart N+1.
- Latency: a pair pushed into an empty FIFO before sampstart_i begins on sdata_o one BCLK after that sampstart.
- A push in the same cycle as sampstart_i into an empty FIFO is not used for that frame.
- underrun_o is asserted in the cycle after sampstart_i.
- level_o and sample_ready_o update in the cycle after a push or pop.

## Configuration
- I2S_TX_HOLD_LAST_EN:
  - Defined: every pop also stores the popped pair in a last-pair register. On underrun, the last-pair frame is reloaded, so the last pair repeats.
  - Undefined: no last-pair register is built, and underrun loads an all-zero frame (silence).
  - underrun_o behaves identically in both builds.

## Test plan
- Reset then free-run, no pushes:
  - sdata_o stays 0.
  - underrun_o pulses once per sampstart_i.
  - level_o=0 and sample_ready_o=1.
- DATA_W=24; push L=0xA5A5A5, R=0x5A5A5A; run two frames:
  - Capture sdata_o on each BCLK rise, starting one BCLK after sampstart.
  - Captured bits = A5A5A5 00 5A5A5A 00 (hex), and the final bit is output at the following sampstart.
- Push 4 pairs with no sampstart_i:
  - level_o=4 and sample_ready_o=0.
  - A 5th push is refused.
  - Pairs come out in FIFO order on four successive frames.
- Full FIFO with sample_valid_i high in the same cycle as sampstart_i:
  - The pop occurs and the push is refused.
  - Next cycle level_o=3 and sample_ready_o=1.
- Underrun after pair L=0x123456, R=0x654321:
  - With I2S_TX_HOLD_LAST_EN: the same bits repeat.
  - Without it: 64 zero bits.
  - underrun_o pulses in both builds.
- Assert rst_n_i low mid-frame, asynchronously to clk_i:
  - sdata_o=0 and level_o=0 immediately.
  - After release, a new push appears from the next sampstart.
